// File: rtl/fp_accum_stream.sv
// fp_accum_stream: FP32 stream accumulator keeping ADD_LAT interleaved partial sums in a pipelined adder, then reducing them.
module ahfp_add_sub_multi #(
  parameter int LAT = 7
) (
  input  logic        clk,
  input  logic [31:0] dataa,
  input  logic [31:0] datab,
  output logic [31:0] result
);
  // Round-to-nearest-even; subnormal inputs and results flush to zero; Inf/NaN are passed through.
  function automatic logic [31:0] fadd(input logic [31:0] a, input logic [31:0] b);
    logic [31:0] x, y;
    logic [26:0] mx, my, m;
    logic [53:0] sh;
    logic [27:0] s;
    logic [24:0] mr;
    logic signed [9:0] e;
    logic [7:0] d;
    int p;
    x = (a[30:0] >= b[30:0]) ? a : b;
    y = (a[30:0] >= b[30:0]) ? b : a;
    mx = (x[30:23] == 8'd0) ? 27'd0 : {1'b1, x[22:0], 3'b000};
    my = (y[30:23] == 8'd0) ? 27'd0 : {1'b1, y[22:0], 3'b000};
    d = x[30:23] - y[30:23];
    sh = {my, 27'd0} >> ((d > 8'd30) ? 8'd30 : d);
    my = sh[53:27] | {26'd0, |sh[26:0]};
    e = {2'b00, x[30:23]};
    if (x[31] == y[31]) begin
      s = {1'b0, mx} + {1'b0, my};
      m = s[27] ? {s[27:2], s[1] | s[0]} : s[26:0];
      e = e + {9'd0, s[27]};
    end else begin
      m = mx - my;
      p = 0;
      for (int i = 0; i < 27; i++) if (m[i]) p = i;
      m = m << (26 - p);
      e = e - 10'(26 - p);
    end
    mr = {1'b0, m[26:3]} + {24'd0, m[2] & (m[3] | m[1] | m[0])};
    if (mr[24]) begin
      mr = mr >> 1;
      e = e + 10'sd1;
    end
    if (x[30:23] == 8'hff) return x;
    if (m == 27'd0) return {x[31] & y[31], 31'd0};
    if (e <= 0) return {x[31], 31'd0};
    if (e >= 255) return {x[31], 8'hff, 23'd0};
    return {x[31], e[7:0], mr[22:0]};
  endfunction

  logic [31:0] sum_d;
  logic [31:0] pipe_q [LAT];

  always_comb sum_d = fadd(dataa, datab);

  always_ff @(posedge clk) begin
    pipe_q[0] <= sum_d;
    for (int i = 1; i < LAT; i++) pipe_q[i] <= pipe_q[i-1];
  end

  assign result = pipe_q[LAT-1];
endmodule

module fp_accum_stream #(
  parameter int ADD_LAT = 7,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_data,
  input  logic             in_neg,
  input  logic             finish,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      result,
  output logic [CNT_W-1:0] count
);
  typedef enum logic [1:0] {IDLE, ACCUM, DRAIN, OUT} state_t;

  state_t             state_q, state_d;
  logic [ADD_LAT-1:0] tag_q, tag_d;
  logic [31:0]        hold_q, hold_d, res_q, res_d, add_a, add_b, add_res;
  logic               hold_v_q, hold_v_d, acc, head, new_tag, clr;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  assign in_ready  = state_q == ACCUM;
  assign out_valid = state_q == OUT;
  assign result    = out_valid ? res_q : 32'd0;
  assign count     = out_valid ? cnt_q : '0;
  assign acc       = in_valid & in_ready;
  assign head      = tag_q[ADD_LAT-1];

  always_comb begin
    state_d  = state_q;
    hold_d   = hold_q;
    hold_v_d = hold_v_q;
    res_d    = res_q;
    cnt_d    = cnt_q;
    add_a    = 32'd0;
    add_b    = 32'd0;
    new_tag  = 1'b0;
    clr      = 1'b0;
    case (state_q)
      IDLE: begin
        clr     = start;
        state_d = start ? ACCUM : IDLE;
      end
      ACCUM: begin
        clr = start;
        if (!start) begin
          add_a   = acc ? {in_data[31] ^ in_neg, in_data[30:0]} : 32'd0;
          add_b   = head ? add_res : 32'd0;
          new_tag = acc | head;
          cnt_d   = cnt_q + CNT_W'(acc && !(&cnt_q));
          state_d = finish ? DRAIN : ACCUM;
        end
      end
      DRAIN: begin
        // Pair each emerging partial sum with the held one; a lone survivor with all tags clear is the total.
        if (head && !hold_v_q) begin
          hold_d   = add_res;
          hold_v_d = 1'b1;
        end else if (head) begin
          add_a    = add_res;
          add_b    = hold_q;
          new_tag  = 1'b1;
          hold_v_d = 1'b0;
        end else if (tag_q == '0) begin
          res_d   = hold_v_q ? hold_q : 32'd0;
          state_d = OUT;
        end
      end
      OUT: state_d = out_ready ? IDLE : OUT;
      default: state_d = IDLE;
    endcase
    if (clr) begin
      cnt_d    = '0;
      hold_v_d = 1'b0;
    end
    tag_d = clr ? '0 : {tag_q[ADD_LAT-2:0], new_tag};
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      tag_q    <= '0;
      hold_q   <= 32'd0;
      hold_v_q <= 1'b0;
      res_q    <= 32'd0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      tag_q    <= tag_d;
      hold_q   <= hold_d;
      hold_v_q <= hold_v_d;
      res_q    <= res_d;
      cnt_q    <= cnt_d;
    end
  end

  ahfp_add_sub_multi #(.LAT(ADD_LAT)) u_add (
    .clk   (clk),
    .dataa (add_a),
    .datab (add_b),
    .result(add_res)
  );
endmodule
